// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU/DMA memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {REQ_CPU, REQ_DMA} req_id_t;

  localparam int unsigned ARB_RR    = 0;
  localparam int unsigned ARB_FIXED = 1;

  // Wide enough for RD_LAT-1 with RD_LAT in 1..4
  localparam int unsigned LAT_W = 2;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and DMA requesters.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic    cpu_req,
  input  logic    dma_req,
  input  req_id_t last_win,
  output req_id_t win_c
);

  // On a tie, round-robin favours whoever lost last time; fixed mode always favours CPU
  always_comb begin
    win_c = REQ_CPU;
    if (dma_req && !cpu_req) begin
      win_c = REQ_DMA;
    end else if (cpu_req && dma_req && (ARB_MODE != ARB_FIXED) && (last_win == REQ_CPU)) begin
      win_c = REQ_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for a single-port memory: IDLE -> ISSUE -> WAIT per access.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned ARB_MODE = ARB_RR
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t           state, state_d;
  req_id_t          win, win_d;
  req_id_t          last_win, last_win_d;
  req_id_t          pick_c;
  logic [LAT_W-1:0] lat_cnt, lat_cnt_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic             issue_d, rv_d;
  logic             cpu_gnt_d, dma_gnt_d, cpu_rvalid_d, dma_rvalid_d;
  logic             mem_en_d, mem_we_d, busy_d;

  mem_arb_pick #(.ARB_MODE(ARB_MODE)) u_pick (
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .last_win (last_win),
    .win_c    (pick_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, capture registers, and the strobes for the cycle the next state occupies
  always_comb begin
    state_d    = state;
    win_d      = win;
    last_win_d = last_win;
    lat_cnt_d  = lat_cnt;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    unique case (state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          state_d = ISSUE;
          win_d   = pick_c;
          if (pick_c == REQ_DMA) begin
            we_d    = dma_we;
            addr_d  = dma_addr;
            wdata_d = dma_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ISSUE: begin
        last_win_d = win;
        if (we_q) begin
          state_d = IDLE;
        end else begin
          state_d   = WAIT;
          lat_cnt_d = LAT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          state_d = IDLE;
        end else begin
          lat_cnt_d = lat_cnt - LAT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    issue_d      = (state_d == ISSUE);
    rv_d         = (state_d == WAIT) && (lat_cnt_d == '0);
    mem_en_d     = issue_d;
    mem_we_d     = issue_d && we_d;
    cpu_gnt_d    = issue_d && (win_d == REQ_CPU);
    dma_gnt_d    = issue_d && (win_d == REQ_DMA);
    cpu_rvalid_d = rv_d && (win_d == REQ_CPU);
    dma_rvalid_d = rv_d && (win_d == REQ_DMA);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win        <= REQ_CPU;
      last_win   <= REQ_DMA;
      lat_cnt    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      win        <= win_d;
      last_win   <= last_win_d;
      lat_cnt    <= lat_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cpu_gnt    <= cpu_gnt_d;
      dma_gnt    <= dma_gnt_d;
      cpu_rvalid <= cpu_rvalid_d;
      dma_rvalid <= dma_rvalid_d;
      mem_en     <= mem_en_d;
      mem_we     <= mem_we_d;
      busy       <= busy_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // Read data is shared; each consumer qualifies it with its own rvalid
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: inst0 round-robin RD_LAT=1, inst1 fixed-priority RD_LAT=1, inst2 round-robin RD_LAT=4.
module tb_mem_port_arbiter;

  typedef struct {
    int          inst;
    bit          rv;
    bit          dma;
    int          cyc;
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  logic        cpu_req[3], dma_req[3], cpu_we[3], dma_we[3];
  logic [31:0] cpu_addr[3], dma_addr[3], cpu_wdata[3], dma_wdata[3];
  logic        cpu_gnt[3], dma_gnt[3], cpu_rvalid[3], dma_rvalid[3];
  logic        mem_en[3], mem_we[3], busy[3];
  logic [31:0] cpu_rdata[3], dma_rdata[3], mem_addr[3], mem_wdata[3], mem_rdata[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned LAT  = (g == 2) ? 4 : 1;
    localparam int unsigned MODE = (g == 1) ? 1 : 0;

    logic [31:0] wr_mem [256];
    logic        wr_vld [256];
    logic [31:0] pipe   [4];
    logic [7:0]  a;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT), .ARB_MODE(MODE)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req    (cpu_req[g]),
      .cpu_we     (cpu_we[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_gnt    (cpu_gnt[g]),
      .cpu_rvalid (cpu_rvalid[g]),
      .cpu_rdata  (cpu_rdata[g]),
      .dma_req    (dma_req[g]),
      .dma_we     (dma_we[g]),
      .dma_addr   (dma_addr[g]),
      .dma_wdata  (dma_wdata[g]),
      .dma_gnt    (dma_gnt[g]),
      .dma_rvalid (dma_rvalid[g]),
      .dma_rdata  (dma_rdata[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g])
    );

    assign a = mem_addr[g][7:0];

    // Memory model: default image (0x10 holds DEADBEEF, else A5A500xx) overlaid by writes
    always @(posedge clk) begin
      if (rst) begin
        for (int k = 0; k < 256; k++) wr_vld[k] <= 1'b0;
      end else if (mem_en[g] && mem_we[g]) begin
        wr_mem[a] <= mem_wdata[g];
        wr_vld[a] <= 1'b1;
      end
      pipe[0] <= (mem_en[g] && !mem_we[g])
                 ? (wr_vld[a] ? wr_mem[a] : ((a == 8'h10) ? 32'hDEAD_BEEF : {24'hA5A5_00, a}))
                 : 32'h0BAD_0BAD;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign mem_rdata[g] = pipe[LAT-1];
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, bit dma, bit on, bit we, logic [31:0] addr, logic [31:0] data);
    if (dma) begin
      dma_req[i] = on; dma_we[i] = we; dma_addr[i] = addr; dma_wdata[i] = data;
    end else begin
      cpu_req[i] = on; cpu_we[i] = we; cpu_addr[i] = addr; cpu_wdata[i] = data;
    end
  endtask

  task automatic exp_gnt(int i, bit dma, int c, bit we, logic [31:0] addr, logic [31:0] data);
    exp_t e;
    e.inst = i; e.rv = 1'b0; e.dma = dma; e.cyc = c; e.we = we; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic exp_rv(int i, bit dma, int c, logic [31:0] data);
    exp_t e;
    e.inst = i; e.rv = 1'b1; e.dma = dma; e.cyc = c; e.we = 1'b0; e.addr = 32'h0; e.data = data;
    sb.push_back(e);
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs(int i);
    return {busy[i], cpu_gnt[i], dma_gnt[i], cpu_rvalid[i], dma_rvalid[i], mem_en[i], mem_we[i]};
  endfunction

  task automatic check_evt(int i, bit rv, bit dma, bit we, logic [31:0] addr, logic [31:0] data, bit ok);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s inst%0d cyc=%0d: got dma=%0d we=%0d addr=%h data=%h, required no event",
               rv ? "rvalid" : "gnt", i, cyc, dma, we, addr, data);
      return;
    end
    e = sb.pop_front();
    if (e.inst != i || e.rv != rv || e.dma != dma || e.cyc != cyc || e.we != we ||
        e.addr != addr || e.data != data || !ok) begin
      n_bad++;
      $display("FAIL %s inst%0d: got inst=%0d dma=%0d cyc=%0d we=%0d addr=%h data=%h en_busy_ok=%0d, required inst=%0d dma=%0d cyc=%0d we=%0d addr=%h data=%h",
               rv ? "rvalid" : "gnt", i, i, dma, cyc, we, addr, data, ok,
               e.inst, e.dma, e.cyc, e.we, e.addr, e.data);
    end
  endtask

  // Monitor: every gnt/rvalid strobe is matched against the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (cpu_gnt[i] || dma_gnt[i])
          check_evt(i, 1'b0, dma_gnt[i], mem_we[i], mem_addr[i], mem_wdata[i],
                    mem_en[i] && busy[i] && !(cpu_gnt[i] && dma_gnt[i]));
        if (cpu_rvalid[i] || dma_rvalid[i])
          check_evt(i, 1'b1, dma_rvalid[i], 1'b0, 32'h0, dma_rvalid[i] ? dma_rdata[i] : cpu_rdata[i],
                    busy[i] && !(cpu_rvalid[i] && dma_rvalid[i]));
      end
    end
  end

  task automatic drain(int budget);
    exp_t e;
    int   n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    while (sb.size() != 0) begin
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missing_%s inst%0d: got nothing by cyc %0d, required event at cyc %0d",
               e.rv ? "rvalid" : "gnt", e.inst, cyc, e.cyc);
    end
    step(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < 3; i++) begin
      set_req(i, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_req(i, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    step(3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_outs_inst%0d", i), 64'(outs(i)), 64'h0);
      chk($sformatf("reset_mem_bus_inst%0d", i), {mem_addr[i], mem_wdata[i]}, 64'h0);
    end
    rst = 1'b0;
    step(2);

    // Round-robin ties: CPU, DMA, CPU, DMA, writes two cycles apart
    t = cyc;
    set_req(0, 1'b0, 1'b1, 1'b1, 32'h30, 32'h1111_1111);
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h2222_2222);
    exp_gnt(0, 1'b0, t+1, 1'b1, 32'h30, 32'h1111_1111);
    exp_gnt(0, 1'b1, t+3, 1'b1, 32'h40, 32'h2222_2222);
    exp_gnt(0, 1'b0, t+5, 1'b1, 32'h30, 32'h1111_1111);
    exp_gnt(0, 1'b1, t+7, 1'b1, 32'h40, 32'h2222_2222);
    step(6);
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(2);
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drain(20);

    // Lone CPU read of 0x10 with RD_LAT=1
    t = cyc;
    set_req(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    exp_gnt(0, 1'b0, t+1, 1'b0, 32'h10, 32'h0);
    exp_rv(0, 1'b0, t+2, 32'hDEAD_BEEF);
    step(2);
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t1_busy_in_wait", 64'(busy[0]), 64'h1);
    step(1);
    @(negedge clk);
    chk("t1_busy_after", 64'(busy[0]), 64'h0);
    drain(10);

    // DMA writes 0x55 to 0x20, then CPU reads it back
    t = cyc;
    set_req(0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h55);
    exp_gnt(0, 1'b1, t+1, 1'b1, 32'h20, 32'h55);
    step(2);
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    exp_gnt(0, 1'b0, t+3, 1'b0, 32'h20, 32'h0);
    exp_rv(0, 1'b0, t+4, 32'h55);
    step(2);
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drain(10);

    // Fixed priority: CPU takes three ties, DMA only after CPU lets go
    t = cyc;
    set_req(1, 1'b0, 1'b1, 1'b1, 32'h50, 32'hC0C0_0001);
    set_req(1, 1'b1, 1'b1, 1'b1, 32'h60, 32'hD0D0_0002);
    exp_gnt(1, 1'b0, t+1, 1'b1, 32'h50, 32'hC0C0_0001);
    exp_gnt(1, 1'b0, t+3, 1'b1, 32'h50, 32'hC0C0_0001);
    exp_gnt(1, 1'b0, t+5, 1'b1, 32'h50, 32'hC0C0_0001);
    exp_gnt(1, 1'b1, t+7, 1'b1, 32'h60, 32'hD0D0_0002);
    step(6);
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(2);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drain(20);

    // RD_LAT=4: DMA read, CPU request arriving mid-wait
    t = cyc;
    set_req(2, 1'b1, 1'b1, 1'b0, 32'h08, 32'h0);
    exp_gnt(2, 1'b1, t+1, 1'b0, 32'h08, 32'h0);
    exp_rv(2, 1'b1, t+5, 32'hA5A5_0008);
    step(2);
    set_req(2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(2, 1'b0, 1'b1, 1'b0, 32'h09, 32'h0);
    exp_gnt(2, 1'b0, t+7, 1'b0, 32'h09, 32'h0);
    exp_rv(2, 1'b0, t+11, 32'hA5A5_0009);
    step(6);
    set_req(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drain(20);

    // Reset during WAIT: outputs clear at once, no rvalid, next tie back to CPU
    t = cyc;
    set_req(2, 1'b0, 1'b1, 1'b0, 32'h0A, 32'h0);
    exp_gnt(2, 1'b0, t+1, 1'b0, 32'h0A, 32'h0);
    step(2);
    set_req(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1);
    rst = 1'b1;
    #1;
    chk("t5_rst_outs", 64'(outs(2)), 64'h0);
    chk("t5_rst_mem_bus", {mem_addr[2], mem_wdata[2]}, 64'h0);
    step(2);
    rst = 1'b0;
    step(8);
    t = cyc;
    set_req(2, 1'b0, 1'b1, 1'b1, 32'h70, 32'h7777_7777);
    set_req(2, 1'b1, 1'b1, 1'b1, 32'h71, 32'h8888_8888);
    exp_gnt(2, 1'b0, t+1, 1'b1, 32'h70, 32'h7777_7777);
    exp_gnt(2, 1'b1, t+3, 1'b1, 32'h71, 32'h8888_8888);
    step(2);
    set_req(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(2);
    set_req(2, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
